// File: rtl/quad_corner_finder_if.sv
// Frame-scan handshake and corner result bus for quad_corner_finder.
// master drives start/threshold/pixels; slave (the finder) returns busy/done/found/corners.
interface quad_corner_finder_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned PIX_W   = 8
);
    logic                   start;
    logic [PIX_W-1:0]       threshold;
    logic                   pixel_valid;
    logic [PIX_W-1:0]       pixel_in;
    logic                   busy;
    logic                   done;
    logic                   found;
    logic [8*COORD_W-1:0]   corners;

    modport master (
        output start, threshold, pixel_valid, pixel_in,
        input  busy, done, found, corners
    );

    modport slave (
        input  start, threshold, pixel_valid, pixel_in,
        output busy, done, found, corners
    );
endinterface

// File: rtl/quad_corner_finder.sv
// Streaming quadrilateral corner finder: thresholds a raster frame and tracks the TL/TR/BL/BR extremes.
// Define CORNER_HOLD_EN to keep the previous corners after an empty frame instead of loading defaults.
module quad_corner_finder #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned FRAME_W = 1024,
    parameter int unsigned FRAME_H = 768,
    parameter int unsigned PIX_W   = 8
) (
    input logic                  clk,
    input logic                  reset,
    quad_corner_finder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_e;

    localparam logic [COORD_W-1:0]   ZERO   = '0;
    localparam logic [COORD_W-1:0]   X_LAST = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0]   Y_LAST = COORD_W'(FRAME_H - 1);
    localparam logic [COORD_W:0]     D_OFS  = (COORD_W + 1)'(FRAME_H - 1);
    localparam logic [8*COORD_W-1:0] DEFAULT_CORNERS =
        {ZERO, ZERO, X_LAST, ZERO, ZERO, Y_LAST, X_LAST, Y_LAST};

    state_e state_q, state_d;

    logic [COORD_W-1:0]   x_q, y_q;
    logic [PIX_W-1:0]     thr_q;
    logic                 s1_vld_q, s1_fg_q;
    logic [COORD_W-1:0]   s1_x_q, s1_y_q;
    logic [COORD_W:0]     s1_s_q, s1_d_q;
    logic                 acc_fg_q;
    logic [COORD_W:0]     tl_s_q, br_s_q, tr_d_q, bl_d_q;
    logic [COORD_W-1:0]   tl_x_q, tl_y_q, tr_x_q, tr_y_q, bl_x_q, bl_y_q, br_x_q, br_y_q;
    logic                 done_q, found_q;
    logic [8*COORD_W-1:0] corners_q;

    logic accept, last_px;

    // A pixel presented in the same cycle as start belongs to no frame.
    assign accept  = (state_q == SCAN) && bus.pixel_valid && !bus.start;
    assign last_px = accept && (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SCAN:    if (last_px) state_d = FLUSH;
                FLUSH:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.done    = done_q;
        bus.found   = found_q;
        bus.corners = corners_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            thr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_fg_q   <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_s_q    <= '0;
            s1_d_q    <= '0;
            acc_fg_q  <= 1'b0;
            tl_s_q    <= '0;
            br_s_q    <= '0;
            tr_d_q    <= '0;
            bl_d_q    <= '0;
            tl_x_q    <= '0;
            tl_y_q    <= '0;
            tr_x_q    <= '0;
            tr_y_q    <= '0;
            bl_x_q    <= '0;
            bl_y_q    <= '0;
            br_x_q    <= '0;
            br_y_q    <= '0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            corners_q <= DEFAULT_CORNERS;
        end else begin
            done_q <= (state_q == DONE);

            if (bus.start) begin
                // Restart drops the in-flight stage-1 pixel along with the accumulators.
                x_q      <= '0;
                y_q      <= '0;
                thr_q    <= bus.threshold;
                s1_vld_q <= 1'b0;
                acc_fg_q <= 1'b0;
            end else begin
                s1_vld_q <= accept;
                if (accept) begin
                    s1_fg_q <= (bus.pixel_in >= thr_q);
                    s1_x_q  <= x_q;
                    s1_y_q  <= y_q;
                    s1_s_q  <= {1'b0, x_q} + {1'b0, y_q};
                    s1_d_q  <= {1'b0, x_q} + D_OFS - {1'b0, y_q};
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end

                if (s1_vld_q && s1_fg_q) begin
                    acc_fg_q <= 1'b1;
                    if (!acc_fg_q || s1_s_q < tl_s_q) begin
                        tl_s_q <= s1_s_q; tl_x_q <= s1_x_q; tl_y_q <= s1_y_q;
                    end
                    if (!acc_fg_q || s1_s_q > br_s_q) begin
                        br_s_q <= s1_s_q; br_x_q <= s1_x_q; br_y_q <= s1_y_q;
                    end
                    if (!acc_fg_q || s1_d_q > tr_d_q) begin
                        tr_d_q <= s1_d_q; tr_x_q <= s1_x_q; tr_y_q <= s1_y_q;
                    end
                    if (!acc_fg_q || s1_d_q < bl_d_q) begin
                        bl_d_q <= s1_d_q; bl_x_q <= s1_x_q; bl_y_q <= s1_y_q;
                    end
                end
            end

            if (state_q == DONE) begin
                found_q <= acc_fg_q;
                if (acc_fg_q) begin
                    corners_q <= {tl_x_q, tl_y_q, tr_x_q, tr_y_q,
                                  bl_x_q, bl_y_q, br_x_q, br_y_q};
                end else begin
`ifdef CORNER_HOLD_EN
                    corners_q <= corners_q;
`else
                    corners_q <= DEFAULT_CORNERS;
`endif
                end
            end
        end
    end
endmodule
